dmem_arbiter: RTL and testbench

Shares the single-port data memory between the pipeline's memory stage (CPU port) and a block-transfer requester such as the AES engine (ACC port). CPU accesses are single words with fixed priority. ACC accesses are word bursts with a guaranteed anti-starvation grant. The block drives the memory port and tells the pipeline when to stall. It sits between the EX/MEM boundary of the pipelined core and the data memory.

---
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between single-word CPU accesses
// (fixed priority) and ACC word bursts with an anti-starvation grant.
`default_nettype none

module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int BURST_W      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  // CPU port
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_wdata,
  output logic               cpu_stall,
  output logic [DW-1:0]      cpu_rdata,
  output logic               cpu_rvalid,
  // ACC burst port
  input  logic               acc_req,
  input  logic               acc_we,
  input  logic [AW-1:0]      acc_addr,
  input  logic [BURST_W-1:0] acc_len,
  output logic               acc_gnt,
  input  logic [DW-1:0]      acc_wdata,
  output logic               acc_wready,
  output logic [DW-1:0]      acc_rdata,
  output logic               acc_rvalid,
  output logic               acc_done,
  // memory port
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state;
  logic [SCW-1:0]     starve_cnt;
  logic [BURST_W-1:0] idx;
  logic [BURST_W-1:0] len_q;
  logic               we_q;
  logic [AW-1:0]      base_q;

  logic               starved;
  logic               cpu_sel;
  logic               acc_sel;
  logic               in_burst;
  logic               last_beat;
  logic [AW-1:0]      beat_addr;

  assign starved   = acc_req && (starve_cnt == STARVE_MAX);
  assign cpu_sel   = (state == IDLE) && cpu_req && !starved;
  assign acc_sel   = (state == IDLE) && !cpu_sel && acc_req;
  assign in_burst  = (state == BURST);
  assign last_beat = in_burst && (idx == len_q);
  assign beat_addr = base_q + {{(AW-BURST_W-2){1'b0}}, idx, 2'b00};

  // IDLE-phase terms are gated with reset so every output reads 0 while it is held.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    acc_wready = 1'b0;
    acc_gnt    = reset && acc_sel;
    cpu_stall  = reset && cpu_req && !cpu_sel;
    if (reset && cpu_sel) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (in_burst) begin
      mem_en     = 1'b1;
      mem_we     = we_q;
      mem_addr   = beat_addr;
      mem_wdata  = we_q ? acc_wdata : '0;
      acc_wready = we_q;
    end
  end

  assign cpu_rdata = reset ? mem_rdata : '0;
  assign acc_rdata = reset ? mem_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      idx        <= '0;
      len_q      <= '0;
      we_q       <= 1'b0;
      base_q     <= '0;
      cpu_rvalid <= 1'b0;
      acc_rvalid <= 1'b0;
      acc_done   <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_sel && !cpu_we;
      acc_rvalid <= in_burst && !we_q;
      acc_done   <= last_beat;
      case (state)
        IDLE: begin
          if (cpu_sel && acc_req && (starve_cnt != STARVE_MAX))
            starve_cnt <= starve_cnt + SCW'(1);
          if (acc_sel) begin
            we_q       <= acc_we;
            base_q     <= acc_addr;
            len_q      <= acc_len;
            idx        <= '0;
            starve_cnt <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          idx <= idx + 1'b1;
          if (idx == len_q)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven vectors plus hand-written burst, starvation and reset sequences.
`default_nettype none

module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        acc_req, acc_we;
  logic [31:0] acc_addr;
  logic [3:0]  acc_len;
  logic        acc_gnt, acc_wready, acc_rvalid, acc_done;
  logic [31:0] acc_wdata, acc_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.AW(32), .DW(32), .BURST_W(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_len(acc_len),
    .acc_gnt(acc_gnt), .acc_wdata(acc_wdata), .acc_wready(acc_wready),
    .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid), .acc_done(acc_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction

  // Memory model: read data appears the cycle after a read is issued.
  always @(posedge clk)
    mem_rdata <= (mem_en && !mem_we) ? rd_fn(mem_addr) : 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    acc_req = 0; acc_we = 0; acc_addr = 0; acc_len = 0; acc_wdata = 0;
  endtask

  typedef struct {
    logic        creq, cwe;
    logic [31:0] caddr, cwdata;
    logic        areq, awe;
    logic [31:0] aaddr;
    logic [3:0]  alen;
    logic [31:0] awdata;
    logic        en, we;
    logic [31:0] addr, wdata;
    logic        stall, gnt, wready, crv, arv, done;
    logic [31:0] crdata;
  } vec_t;

  vec_t vecs[11];

  // CPU has priority: both high for 8 cycles gives 8 CPU grants, then the ACC grant.
  task automatic run_starve(input string tag);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    acc_req = 1; acc_we = 0; acc_addr = 32'h300; acc_len = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cycle();
      settle();
      check($sformatf("%s_cpu%0d", tag, i), {61'd0, cpu_stall, acc_gnt, mem_en}, 64'b001);
    end
    next_cycle(); settle();
    check({tag, "_gnt"}, {62'd0, acc_gnt, cpu_stall}, 64'b11);
    next_cycle(); acc_req = 0; settle();
    check({tag, "_beat"}, {31'd0, cpu_stall, mem_addr}, {31'd0, 1'b1, 32'h300});
    next_cycle(); settle();
    check({tag, "_after"}, {29'd0, cpu_stall, acc_rvalid, acc_done, mem_addr}, {29'd0, 3'b011, 32'h40});
    check({tag, "_ardata"}, {32'd0, acc_rdata}, {32'd0, rd_fn(32'h300)});
    cpu_req = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    cpu_req = 1; cpu_addr = 32'h10; acc_req = 1;
    next_cycle(); settle();
    check("reset_outputs",
          {56'd0, mem_en, cpu_stall, acc_gnt, acc_wready, cpu_rvalid, acc_rvalid, acc_done, mem_we},
          64'd0);
    idle_inputs();
    next_cycle(); reset = 1;

    //          creq cwe caddr  cwdata   areq awe aaddr  alen awdata  en we addr    wdata    st gn wr crv arv dn crdata
    vecs[0]  = '{0, 0, 32'h0,  32'h0,    0, 0, 32'h0,   0, 32'h0,  0, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0, 32'h0};
    vecs[1]  = '{1, 0, 32'h10, 32'h0,    0, 0, 32'h0,   0, 32'h0,  1, 0, 32'h10,  32'h0,    0, 0, 0, 0, 0, 0, 32'h0};
    vecs[2]  = '{0, 0, 32'h0,  32'h0,    0, 0, 32'h0,   0, 32'h0,  0, 0, 32'h0,   32'h0,    0, 0, 0, 1, 0, 0, 32'hDEADBEEF};
    vecs[3]  = '{0, 0, 32'h0,  32'h0,    1, 1, 32'h100, 3, 32'h0,  0, 0, 32'h0,   32'h0,    0, 1, 0, 0, 0, 0, 32'h0};
    vecs[4]  = '{0, 0, 32'h0,  32'h0,    0, 0, 32'h0,   0, 32'hA0, 1, 1, 32'h100, 32'hA0,   0, 0, 1, 0, 0, 0, 32'h0};
    vecs[5]  = '{1, 0, 32'h20, 32'h0,    0, 0, 32'h0,   0, 32'hA1, 1, 1, 32'h104, 32'hA1,   1, 0, 1, 0, 0, 0, 32'h0};
    vecs[6]  = '{1, 0, 32'h20, 32'h0,    0, 0, 32'h0,   0, 32'hA2, 1, 1, 32'h108, 32'hA2,   1, 0, 1, 0, 0, 0, 32'h0};
    vecs[7]  = '{1, 0, 32'h20, 32'h0,    0, 0, 32'h0,   0, 32'hA3, 1, 1, 32'h10C, 32'hA3,   1, 0, 1, 0, 0, 0, 32'h0};
    vecs[8]  = '{1, 0, 32'h20, 32'h0,    0, 0, 32'h0,   0, 32'h0,  1, 0, 32'h20,  32'h0,    0, 0, 0, 0, 0, 1, 32'h0};
    vecs[9]  = '{1, 1, 32'h30, 32'h1234, 0, 0, 32'h0,   0, 32'h0,  1, 1, 32'h30,  32'h1234, 0, 0, 0, 1, 0, 0, rd_fn(32'h20)};
    vecs[10] = '{0, 0, 32'h0,  32'h0,    0, 0, 32'h0,   0, 32'h0,  0, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0, 32'h0};

    for (int i = 0; i < 11; i++) begin
      next_cycle();
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwdata;
      acc_req = vecs[i].areq; acc_we = vecs[i].awe; acc_addr = vecs[i].aaddr; acc_len = vecs[i].alen;
      acc_wdata = vecs[i].awdata;
      settle();
      check($sformatf("vec%0d", i),
            {23'd0, mem_en, mem_we, mem_addr, cpu_stall, acc_gnt, acc_wready, cpu_rvalid, acc_rvalid, acc_done},
            {23'd0, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].stall, vecs[i].gnt, vecs[i].wready,
             vecs[i].crv, vecs[i].arv, vecs[i].done});
      if (vecs[i].we)
        check($sformatf("vec%0d_wdata", i), {32'd0, mem_wdata}, {32'd0, vecs[i].wdata});
      if (vecs[i].crv)
        check($sformatf("vec%0d_crdata", i), {32'd0, cpu_rdata}, {32'd0, vecs[i].crdata});
    end

    // Starvation twice: the second run also shows the counter cleared on the grant.
    next_cycle(); run_starve("starveA");
    next_cycle(); run_starve("starveB");

    // Read burst wrapping past the top of the address space.
    next_cycle(); idle_inputs();
    acc_req = 1; acc_we = 0; acc_addr = 32'hFFFF_FFF8; acc_len = 3;
    settle(); check("wrap_gnt", {63'd0, acc_gnt}, 64'd1);
    begin
      logic [31:0] waddr[4];
      waddr[0] = 32'hFFFF_FFF8; waddr[1] = 32'hFFFF_FFFC; waddr[2] = 32'h0; waddr[3] = 32'h4;
      for (int b = 0; b <= 4; b++) begin
        next_cycle(); acc_req = 0; settle();
        if (b < 4)
          check($sformatf("wrap_addr%0d", b), {31'd0, mem_en, mem_addr}, {31'd0, 1'b1, waddr[b]});
        check($sformatf("wrap_rv%0d", b), {62'd0, acc_rvalid, acc_done},
              {62'd0, (b > 0) ? 1'b1 : 1'b0, (b == 4) ? 1'b1 : 1'b0});
        if (b > 0)
          check($sformatf("wrap_rd%0d", b), {32'd0, acc_rdata}, {32'd0, rd_fn(waddr[b-1])});
      end
    end

    // Reset asserted mid-burst abandons the burst immediately.
    next_cycle(); acc_req = 1; acc_we = 0; acc_addr = 32'h500; acc_len = 3;
    next_cycle(); acc_req = 0;
    next_cycle();
    next_cycle(); settle();
    check("rst_pre", {31'd0, acc_rvalid, mem_addr}, {31'd0, 1'b1, 32'h508});
    reset = 0; #1;
    check("rst_now", {61'd0, mem_en, acc_rvalid, acc_done}, 64'd0);
    next_cycle(); settle();
    check("rst_hold", {61'd0, mem_en, acc_rvalid, acc_done}, 64'd0);
    reset = 1;
    next_cycle(); settle();
    check("rst_idle", {62'd0, mem_en, acc_done}, 64'd0);
    next_cycle(); acc_req = 1; acc_we = 0; acc_addr = 32'h200; acc_len = 1; settle();
    check("new_gnt", {62'd0, acc_gnt, mem_en}, 64'b10);
    next_cycle(); acc_req = 0; settle();
    check("new_beat0", {31'd0, mem_en, mem_addr}, {31'd0, 1'b1, 32'h200});
    next_cycle(); settle();
    check("new_beat1", {31'd0, mem_en, mem_addr}, {31'd0, 1'b1, 32'h204});
    next_cycle(); settle();
    check("new_done", {61'd0, mem_en, acc_rvalid, acc_done}, 64'b011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
